// File: rtl/rsa_operand_loader_pkg.sv
// Shared types and constants for the RSA operand loader.
// Defines the default operand width, the loader state enum and the bytes-per-word helper.
package rsa_pkg;

    localparam int unsigned WORD_SIZE = 32;

    typedef enum logic [2:0] {
        RX_TEXT,
        RX_KEY,
        RX_MOD,
        CHECK,
        LOAD,
        RUN
    } state_e;

    function automatic int unsigned bytes_per_word(input int unsigned word_size);
        return word_size / 8;
    endfunction

endpackage

// File: rtl/rsa_operand_loader_byte_word_shifter.sv
// One operand word register that shifts a byte in at the LSB end.
// Clear is synchronous and takes priority over enable.
module byte_word_shifter #(
    parameter int unsigned WordSize = rsa_pkg::WORD_SIZE
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                enable,
    input  logic [7:0]          byte_in,
    output logic [WordSize-1:0] word
);

    logic [WordSize-1:0] word_q;
    logic [WordSize-1:0] word_d;

    always_comb begin
        word_d = word_q;
        if (clear) begin
            word_d = '0;
        end else if (enable) begin
            word_d = {word_q[WordSize-9:0], byte_in};
        end
    end

    always_ff @(posedge clk) begin
        word_q <= word_d;
    end

    assign word = word_q;

endmodule

// File: rtl/rsa_operand_loader.sv
// Byte-serial frame loader (text, key, mod) in front of the RSA exponentiation datapath.
// Define RSA_MOD_CHECK_EN to reject frames whose modulus is even or below 3.
module rsa_operand_loader
    import rsa_pkg::*;
#(
    parameter int unsigned WordSize   = rsa_pkg::WORD_SIZE,
    parameter int unsigned LoadCycles = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic [WordSize-1:0] input_text,
    output logic [WordSize-1:0] key,
    output logic [WordSize-1:0] mod,
    output logic                load,
    output logic                running,
    input  logic                over,
    output logic                busy,
    output logic                frame_err
);

    localparam int unsigned BPW = bytes_per_word(WordSize);
    localparam int unsigned CW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int unsigned LW  = (LoadCycles > 1) ? $clog2(LoadCycles) : 1;
    localparam logic [CW-1:0] LAST_BYTE = CW'(BPW - 1);
    localparam logic [LW-1:0] LAST_LOAD = LW'(LoadCycles - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] byte_cnt_q, byte_cnt_d;
    logic [LW-1:0] load_cnt_q, load_cnt_d;
    logic          run_first_q, run_first_d;
    logic          rx_ready_q, rx_ready_d;
    logic          load_q, load_d;
    logic          running_q, running_d;
    logic          busy_q, busy_d;
    logic          frame_err_q, frame_err_d;

    logic accept;
    logic word_done;
    logic mod_ok;
    logic shift_text, shift_key, shift_mod;

    assign accept     = rx_valid && rx_ready_q;
    assign word_done  = accept && (byte_cnt_q == LAST_BYTE);
    assign shift_text = accept && (state_q == RX_TEXT);
    assign shift_key  = accept && (state_q == RX_KEY);
    assign shift_mod  = accept && (state_q == RX_MOD);

`ifdef RSA_MOD_CHECK_EN
    assign mod_ok = mod[0] && (mod > WordSize'(2));
`else
    assign mod_ok = 1'b1;
`endif

    // Outputs are derived from the next state so they are registered yet line up with the state.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        load_cnt_d  = load_cnt_q;
        run_first_d = 1'b0;
        frame_err_d = 1'b0;

        if (accept) begin
            byte_cnt_d = word_done ? '0 : byte_cnt_q + 1'b1;
        end

        case (state_q)
            RX_TEXT: if (word_done) state_d = RX_KEY;
            RX_KEY:  if (word_done) state_d = RX_MOD;
            RX_MOD:  if (word_done) state_d = CHECK;
            CHECK: begin
                if (mod_ok) begin
                    state_d    = LOAD;
                    load_cnt_d = '0;
                end else begin
                    state_d     = RX_TEXT;
                    frame_err_d = 1'b1;
                end
            end
            LOAD: begin
                if (load_cnt_q == LAST_LOAD) begin
                    state_d     = RUN;
                    run_first_d = 1'b1;
                end else begin
                    load_cnt_d = load_cnt_q + 1'b1;
                end
            end
            // A stale over from the previous operation may still be high on the first RUN cycle.
            RUN:     if (over && !run_first_q) state_d = RX_TEXT;
            default: state_d = RX_TEXT;
        endcase

        rx_ready_d = (state_d == RX_TEXT) || (state_d == RX_KEY) || (state_d == RX_MOD);
        load_d     = (state_d == LOAD);
        running_d  = (state_d == RUN);
        busy_d     = (state_d == CHECK) || (state_d == LOAD) || (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RX_TEXT;
            byte_cnt_q  <= '0;
            load_cnt_q  <= '0;
            run_first_q <= 1'b0;
            rx_ready_q  <= 1'b1;
            load_q      <= 1'b0;
            running_q   <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            load_cnt_q  <= load_cnt_d;
            run_first_q <= run_first_d;
            rx_ready_q  <= rx_ready_d;
            load_q      <= load_d;
            running_q   <= running_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    byte_word_shifter #(.WordSize(WordSize)) u_text (
        .clk     (clk),
        .clear   (reset),
        .enable  (shift_text),
        .byte_in (rx_data),
        .word    (input_text)
    );

    byte_word_shifter #(.WordSize(WordSize)) u_key (
        .clk     (clk),
        .clear   (reset),
        .enable  (shift_key),
        .byte_in (rx_data),
        .word    (key)
    );

    byte_word_shifter #(.WordSize(WordSize)) u_mod (
        .clk     (clk),
        .clear   (reset),
        .enable  (shift_mod),
        .byte_in (rx_data),
        .word    (mod)
    );

    assign rx_ready  = rx_ready_q;
    assign load      = load_q;
    assign running   = running_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_rsa_operand_loader.sv
// Self-checking bench for rsa_operand_loader: a timeline model of the frame/load/run sequence
// is compared against the DUT on every cycle, plus directed literal checks and random frames.
module tb_rsa_operand_loader;

    localparam int unsigned WS  = 32;
    localparam int unsigned LC  = 2;
    localparam int unsigned BPW = WS / 8;
    localparam longint unsigned MASK = 64'hFFFF_FFFF;
`ifdef RSA_MOD_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [WS-1:0] input_text, key, mod;
    logic          load, running, over, busy, frame_err;

    always #5 clk = ~clk;

    rsa_operand_loader #(.WordSize(WS), .LoadCycles(LC)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .input_text (input_text),
        .key        (key),
        .mod        (mod),
        .load       (load),
        .running    (running),
        .over       (over),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    // Model: t = cycles since the edge that took the last mod byte (0 while receiving).
    longint unsigned mw[3];
    int  nb;
    int  t;
    bit  mferr;
    bit  model_on = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            mw[0] = 0; mw[1] = 0; mw[2] = 0;
            nb = 0; t = 0; mferr = 1'b0; model_on = 1'b1;
        end else if (model_on) begin
            mferr = 1'b0;
            if (t == 0) begin
                if (rx_valid) begin
                    mw[nb / BPW] = ((mw[nb / BPW] << 8) | longint'(rx_data)) & MASK;
                    nb++;
                    if (nb == 3 * BPW) begin
                        nb = 0;
                        t  = 1;
                    end
                end
            end else if (t == 1) begin
                if (CHK && (mw[2] < 3 || mw[2] % 2 == 0)) begin
                    t = 0;
                    mferr = 1'b1;
                end else begin
                    t = 2;
                end
            end else if (t > 2 + LC && over) begin
                t = 0;
            end else begin
                t++;
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("rx_ready",   rx_ready,   64'(t == 0));
            chk("busy",       busy,       64'(t != 0));
            chk("load",       load,       64'(t >= 2 && t <= 1 + LC));
            chk("running",    running,    64'(t >= 2 + LC));
            chk("frame_err",  frame_err,  64'(mferr));
            chk("input_text", input_text, mw[0]);
            chk("key",        key,        mw[1]);
            chk("mod",        mod,        mw[2]);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done = 1'b0;
        bit r;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            r = rx_ready;
            @(posedge clk);
            #2;
            if (r) done = 1'b1;
        end
        rx_valid = 1'b0;
        chk("byte_accept_timeout", 64'(done), 64'd1);
    endtask

    task automatic send_word(input logic [WS-1:0] w, input int gap, input bit rnd_gap);
        logic [WS-1:0] v;
        v = w;
        for (int i = 0; i < int'(BPW); i++) begin
            send_byte(v[WS-1:WS-8]);
            v = v << 8;
            if (rnd_gap) cyc(int'($urandom_range(0, 2)));
            else         cyc(gap);
        end
    endtask

    task automatic send_frame(input logic [WS-1:0] tx, input logic [WS-1:0] k,
                              input logic [WS-1:0] m, input int gap, input bit rnd_gap);
        send_word(tx, gap, rnd_gap);
        send_word(k,  gap, rnd_gap);
        send_word(m,  gap, rnd_gap);
    endtask

    // Drives over (steady or random) until the loader accepts bytes again.
    task automatic return_to_rx(input bit rnd);
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (rx_ready) done = 1'b1;
            else begin
                over = rnd ? ($urandom_range(0, 3) == 0) : 1'b1;
                cyc(1);
            end
        end
        over = 1'b0;
        chk("return_timeout", 64'(done), 64'd1);
    endtask

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; over = 1'b0;
        cyc(3);
        reset = 1'b0;
        chk("rst_ready", rx_ready, 64'd1);
        chk("rst_text",  input_text, 64'd0);
        chk("rst_busy",  busy, 64'd0);

        // Nominal frame; send_frame returns in cycle N+1.
        send_frame(32'h2A, 32'h11, 32'hCA1, 0, 1'b0);
        chk("nom_busy_check", busy, 64'd1);
        chk("nom_load_check", load, 64'd0);
        cyc(1); chk("nom_load1", load, 64'd1);
        cyc(1); chk("nom_load2", load, 64'd1);
        cyc(1); chk("nom_load_off", load, 64'd0);
        chk("nom_running", running, 64'd1);
        chk("nom_text", input_text, 64'h2A);
        chk("nom_key",  key,        64'h11);
        chk("nom_mod",  mod,        64'hCA1);

        // Back-pressure in RUN, then the held byte becomes the first text byte.
        cyc(1);
        rx_valid = 1'b1; rx_data = 8'hAB;
        cyc(5);
        chk("bp_ready", rx_ready, 64'd0);
        chk("bp_text",  input_text, 64'h2A);
        over = 1'b1;
        cyc(1);
        over = 1'b0;
        chk("ret_ready",   rx_ready, 64'd1);
        chk("ret_running", running,  64'd0);
        chk("ret_busy",    busy,     64'd0);
        send_byte(8'hAB);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        send_word(32'h5, 0, 1'b0);
        send_word(32'h3B, 0, 1'b0);
        chk("bp_text_new", input_text, 64'hAB010203);

        // Stale over on the first RUN cycle must be ignored.
        cyc(1 + LC);
        chk("stale_first_run", running, 64'd1);
        over = 1'b1;
        cyc(1);
        over = 1'b0;
        chk("stale_ignored", running, 64'd1);
        cyc(50);
        chk("stale_still_run", running, 64'd1);
        over = 1'b1;
        cyc(1);
        over = 1'b0;
        chk("stale_end_run", running, 64'd0);
        chk("stale_end_ready", rx_ready, 64'd1);

        // Even modulus: rejected only when the check is built in.
        send_frame(32'h2A, 32'h11, 32'hCA0, 0, 1'b0);
        cyc(1);
        chk("even_ferr", frame_err, 64'(CHK));
        chk("even_load", load, 64'(!CHK));
        chk("even_ready", rx_ready, 64'(CHK));
        return_to_rx(1'b0);
        send_frame(32'h7, 32'h3, 32'hCA1, 0, 1'b0);
        cyc(1);
        chk("after_even_load", load, 64'd1);
        return_to_rx(1'b0);

        // Reset in RX_KEY after two key bytes.
        send_word(32'h11223344, 0, 1'b0);
        send_byte(8'h55); send_byte(8'h66);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("mid_rst_text",  input_text, 64'd0);
        chk("mid_rst_key",   key,        64'd0);
        chk("mid_rst_ready", rx_ready,   64'd1);
        send_frame(32'h2A, 32'h11, 32'hCA1, 0, 1'b0);
        cyc(1);
        chk("mid_rst_load", load, 64'd1);
        chk("mid_rst_key2", key,  64'h11);
        return_to_rx(1'b0);

        // One valid in every three cycles.
        send_frame(32'h2A, 32'h11, 32'hCA1, 2, 1'b0);
        chk("gap_text", input_text, 64'h2A);
        chk("gap_key",  key,        64'h11);
        chk("gap_mod",  mod,        64'hCA1);
        return_to_rx(1'b0);

        // Random frames, gaps and over timing.
        for (int f = 0; f < 8; f++) begin
            send_frame(32'($urandom), 32'($urandom), 32'($urandom), 0, 1'b1);
            return_to_rx(1'b1);
        end

        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
